rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum number of BUSY cycles a grant may be held without done; legal range 2..256.
REQ-002 SHALL have parameter CW, default 8: width of the internal timeout counter; TIMEOUT <= 2^CW.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 4 bits: req[i] high = requester i wants the shared resource.
REQ-006 SHALL have port done, input, 1 bit: the granted transaction completes in this cycle.
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant, registered.
REQ-008 SHALL have port sel, output, 2 bits: binary index of the current or last grant, registered; drives the 4-input select mux of the shared resource.
REQ-009 SHALL have port busy, output, 1 bit: high while in state BUSY.
REQ-010 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-012 In IDLE with req == 0, all state SHALL hold and gnt SHALL stay 0.
REQ-013 In IDLE with req != 0, the block SHALL pick the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- ptr is the 2-bit round-robin pointer.
REQ-014 At the same edge as REQ-013: gnt = one-hot of the winner, sel = winner index, state -> BUSY, counter = 0.
- Latency from req high (sampled) to gnt high is exactly 1 cycle.
REQ-015 In BUSY, gnt and sel SHALL hold constant regardless of req changes, including the granted requester dropping req.
REQ-016 In BUSY with done high at an edge, the block SHALL release:
- gnt = 0, state -> IDLE, ptr = sel + 1 (mod 4), counter = 0, timeout = 0.
REQ-017 In BUSY with done low at an edge, the counter SHALL increment if counter < TIMEOUT-1.
REQ-018 In BUSY with done low and counter == TIMEOUT-1, the block SHALL force release as in REQ-016 and set timeout = 1 for exactly one cycle.
REQ-019 If done and the timeout condition coincide, done SHALL win: normal release, timeout stays 0.
REQ-020 done SHALL be ignored in IDLE.
REQ-021 After every release, at least one IDLE cycle SHALL occur before the next grant.
- Grant-to-grant minimum spacing is 2 edges.
REQ-022 sel SHALL retain the last granted index while IDLE; it changes only at a new grant.
REQ-023 gnt SHALL never have more than one bit set; busy SHALL equal |gnt.
REQ-024 The ptr update SHALL wrap modulo 4 (sel = 3 -> ptr = 0).

Reset
REQ-025 rst low SHALL immediately, without a clock edge, force all of the following; this applies mid-transaction as well:
- state = IDLE, gnt = 0, sel = 0, busy = 0, timeout = 0, ptr = 0, counter = 0.
REQ-026 After rst deasserts, the first edge with req != 0 SHALL arbitrate starting from ptr = 0.

Verification
REQ-027 Reset then req = 4'b1111 -> next edge gnt = 0001, sel = 0; done pulse -> gnt = 0000; next grant gnt = 0010, then 0100, then 1000, then 0001.
REQ-028 Single requester: req = 4'b0100 held, done pulses each grant -> gnt alternates 0100 / 0000 every edge pair; sel stays 2.
REQ-029 TIMEOUT = 4, req = 4'b1000, done held low:
- gnt = 1000 for exactly 4 cycles, then gnt = 0000 with timeout = 1 for one cycle.
- ptr = 0; the next req = 4'b1001 grants requester 0.
REQ-030 Coincidence: done asserted in the same cycle counter == TIMEOUT-1 -> normal release, timeout stays 0.
REQ-031 Granted requester drops req mid-BUSY while others assert -> gnt unchanged until done.
- Asserting rst low mid-BUSY -> gnt = 0, sel = 0, busy = 0 immediately, asynchronously.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a grant-hold timeout.
// A grant is held until done, or until TIMEOUT busy cycles elapse without
// done, at which point the grant is forcibly released with a one-cycle
// timeout pulse. The round-robin pointer moves to one past the last winner
// on every release, so each requester gets a fair turn.
module rr_arbiter4 #(
  parameter int TIMEOUT = 16,  // max busy cycles per grant, 2..256
  parameter int CW      = 8    // counter width, TIMEOUT <= 2**CW
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam logic          STATE_IDLE = 1'b0;
  localparam logic          STATE_BUSY = 1'b1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

  logic          state_q,   state_d;
  logic [3:0]    gnt_q,     gnt_d;
  logic [1:0]    sel_q,     sel_d;
  logic [1:0]    ptr_q,     ptr_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          timeout_q, timeout_d;
  logic [1:0]    win;

  // Pick the first requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    win = ptr_q;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win = ptr_q + 2'(i);
      end
    end
  end

  // Next-state logic for the IDLE/BUSY controller and its counters.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        // done is meaningless here; only a request starts a grant.
        if (|req) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          state_d = STATE_BUSY;
          cnt_d   = '0;
        end
      end
      default: begin
        // Grant and select are frozen until release, whatever req does.
        if (done || cnt_q == CNT_LAST) begin
          gnt_d     = 4'b0000;
          state_d   = STATE_IDLE;
          ptr_d     = sel_q + 2'd1;
          cnt_d     = '0;
          // done takes priority: a coinciding done is a normal release.
          timeout_d = ~done;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // State registers; reset is asynchronous and clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: flops use non-blocking assignments so all updates land together.
    if (!rst) begin
      state_q   <= STATE_IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = (state_q == STATE_BUSY);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 (TIMEOUT = 4). A behavioural model
// tracks owner, pointer and cycles-held as plain integers and predicts the
// outputs after every clock edge.
module tb_rr_arbiter4;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_sel;
  int m_held;
  bit m_to;

  rr_arbiter4 #(.TIMEOUT(TO), .CW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_sel = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_release();
    m_busy = 0;
    m_ptr  = (m_sel + 1) % 4;
  endtask

  // One clock edge of the arbiter's rules in plain arithmetic.
  task automatic model_step(input logic [3:0] r, input logic d);
    bit found;
    m_to = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          found = 1;
        end
      end
      if (found) begin
        m_busy = 1; m_sel = m_owner; m_held = 1;
      end
    end else if (d) begin
      model_release();
    end else if (m_held == TO) begin
      model_release();
      m_to = 1;
    end else begin
      m_held++;
    end
  endtask

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_sel), m_busy, m_to};
  endfunction

  function automatic logic [7:0] act_vec();
    return {gnt, sel, busy, timeout};
  endfunction

  // Drive inputs, take one edge, advance the model, settle 1 ns past the edge.
  task automatic cycle(input logic [3:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 4'b1111; done = 1'b0;
    model_reset();
    #3;
    checks++;
    if (act_vec() !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got %b want 00000000", act_vec());
    end
    @(posedge clk); #1;
    rst = 1'b1; req = 4'b0000;
  endtask

  task automatic test_rotation();
    logic [3:0] want [5];
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int g = 0; g < 5; g++) begin
      cycle(4'b1111, 1'b0);
      checks++;
      if (gnt !== want[g] || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_grant%0d: got %b/%b want %b/%b", g, gnt, act_vec(), want[g], exp_vec());
      end
      cycle(4'b1111, 1'b1);
      checks++;
      if (gnt !== 4'b0000 || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rotation_release%0d: got %b want %b", g, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single();
    for (int n = 0; n < 6; n++) begin
      cycle(4'b0100, 1'b1);
      checks++;
      if (sel !== 2'd2 || gnt !== ((n % 2 == 0) ? 4'b0100 : 4'b0000) || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_req step%0d: got %b want %b", n, act_vec(), exp_vec());
      end
    end
    cycle(4'b0000, 1'b0);
  endtask

  task automatic test_timeout();
    int held;
    int pulses;
    held = 0; pulses = 0;
    // Force the pointer to 3 so the timeout release wraps it to 0.
    for (int n = 0; n < 8; n++) begin
      cycle(4'b1000, 1'b0);
      if (gnt === 4'b1000) held++;
      if (timeout === 1'b1) pulses++;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL timeout_step%0d: got %b want %b", n, act_vec(), exp_vec());
      end
      if (timeout === 1'b1) begin
        req = 4'b0000;
        break;
      end
    end
    checks++;
    if (held != TO || pulses != 1) begin
      errors++;
      $display("FAIL timeout_len: got held=%0d pulses=%0d want held=%0d pulses=1", held, pulses, TO);
    end
    cycle(4'b1001, 1'b0);
    checks++;
    if (gnt !== 4'b0001 || timeout !== 1'b0 || act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_wrap: got %b want gnt 0001 (%b)", act_vec(), exp_vec());
    end
    cycle(4'b0000, 1'b1);
  endtask

  task automatic test_coincide();
    cycle(4'b0010, 1'b0);
    for (int n = 0; n < TO - 1; n++) cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b1);
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL coincide: got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_hold();
    logic [3:0] first;
    cycle(4'b0100, 1'b0);
    first = gnt;
    for (int n = 0; n < 2; n++) begin
      cycle(4'b1011, 1'b0);
      checks++;
      if (gnt !== first || act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL hold_step%0d: got %b want %b", n, act_vec(), exp_vec());
      end
    end
    cycle(4'b1011, 1'b1);
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL hold_release: got %b want %b", act_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec() !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %b want 00000000", act_vec());
    end
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(4'b1111, 1'b0);
    checks++;
    if (gnt !== 4'b0001 || act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset_ptr: got %b want %b", act_vec(), exp_vec());
    end
    cycle(4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic d;
    for (int n = 0; n < 400; n++) begin
      r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 9) < 3);
      cycle(r, d);
      checks++;
      if (act_vec() !== exp_vec() || (busy !== |gnt) || ($countones(gnt) > 1)) begin
        errors++;
        $display("FAIL random_step%0d: got %b want %b", n, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_coincide();
    test_hold();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
